// File: rtl/prbs_pkg.sv
// Shared types, widths and LFSR polynomial for the PRBS burst controller.
package prbs_pkg;

    localparam int unsigned LFSR_W = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned REP_W  = 8;

    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_e;

    // x^4 + x^3 + 1 style shift: output bit is s[0], feedback s[1]^s[0] enters at the top
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[1] ^ s[0], s[3:1]};
    endfunction

endpackage

// File: rtl/prbs4_lfsr.sv
// 4-bit PRBS register with synchronous load (priority) and advance enable.
module prbs4_lfsr
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;

    // Load beats advance; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (en_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/prbs_burst_ctrl.sv
// Sequences the PRBS4 generator into repeatable bursts on a valid/ready stream.
module prbs_burst_ctrl
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LFSR_W-1:0] cfg_seed_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic [GAP_W-1:0]  cfg_gap_i,
    input  logic [REP_W-1:0]  cfg_reps_i,
    input  logic              abort_i,
    output logic              dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_seed_o
);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] seed_q, seed_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_seed;
    logic              lfsr_load, lfsr_en;

    logic dout_q, dout_d;
    logic valid_q, valid_d;
    logic last_q, last_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    prbs4_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load_i  (lfsr_load),
        .seed_i  (lfsr_seed),
        .en_i    (lfsr_en),
        .state_o (lfsr_q)
    );

    // State, configuration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seed_q    <= SEED_DEFAULT;
            len_q     <= '0;
            gap_q     <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state, counters, LFSR control and next output values.
    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        len_d     = len_q;
        gap_d     = gap_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = 1'b0;
        lfsr_en   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    if (cfg_seed_i == '0) begin
                        err_d = 1'b1;
                    end else if (cfg_len_i == '0 || cfg_reps_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        seed_d    = cfg_seed_i;
                        len_d     = cfg_len_i;
                        gap_d     = cfg_gap_i;
                        rep_cnt_d = cfg_reps_i;
                        state_d   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                bit_cnt_d = len_q;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (dout_ready_i) begin
                    lfsr_en   = 1'b1;
                    bit_cnt_d = bit_cnt_q - LEN_W'(1);
                    if (bit_cnt_q == LEN_W'(1)) begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        if (rep_cnt_q == REP_W'(1)) begin
                            state_d = ST_DONE;
                        end else if (gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end

        // Every burst reseeds from the latched seed; IDLE always holds the default.
        lfsr_load = (state_q == ST_LOAD) || (state_d == ST_IDLE);
        lfsr_seed = (state_d == ST_IDLE) ? SEED_DEFAULT : seed_q;
        lfsr_d    = lfsr_load ? lfsr_seed : (lfsr_en ? lfsr_step(lfsr_q) : lfsr_q);

        valid_d = (state_d == ST_RUN);
        dout_d  = valid_d & lfsr_d[0];
        last_d  = valid_d && (bit_cnt_d == LEN_W'(1));
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign dout_last_o  = last_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_seed_o   = err_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Self-checking bench for prbs_burst_ctrl against a sequence-level PRBS model.
module tb_prbs_burst_ctrl;
    import prbs_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LFSR_W-1:0] cfg_seed;
    logic [LEN_W-1:0]  cfg_len;
    logic [GAP_W-1:0]  cfg_gap;
    logic [REP_W-1:0]  cfg_reps;
    logic              abort;
    logic              dout, dout_valid, dout_last;
    logic              rdy;
    logic              busy, done, err_seed;

    int n_cmp = 0;
    int n_err = 0;

    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: pattern then ready
    logic [31:0] rdy_pat  = '0;
    bit          ref_bits [0:299];

    always #5 clk = ~clk;

    prbs_burst_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .cfg_seed_i   (cfg_seed),
        .cfg_len_i    (cfg_len),
        .cfg_gap_i    (cfg_gap),
        .cfg_reps_i   (cfg_reps),
        .abort_i      (abort),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (rdy),
        .dout_last_o  (dout_last),
        .busy_o       (busy),
        .done_o       (done),
        .err_seed_o   (err_seed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {26'd0, dout, dout_valid, dout_last, busy, done, err_seed}, 32'd0);
    endtask

    // Bit stream of a PRBS4 seeded with s: b[n+4] = b[n] ^ b[n+1], first bits are s[0..3].
    function automatic void build_ref(input logic [3:0] s, input int n);
        for (int i = 0; i < 4; i++) ref_bits[i] = s[i];
        for (int i = 4; i < n && i < 300; i++) ref_bits[i] = ref_bits[i-4] ^ ref_bits[i-3];
    endfunction

    task automatic run_cmd(input logic [3:0] seed, input logic [7:0] len,
                           input logic [3:0] gap, input logic [7:0] reps);
        int idx, done_reps, low, vk;
        bit in_gap, fin;
        build_ref(seed, int'(len));
        cfg_seed = seed; cfg_len = len; cfg_gap = gap; cfg_reps = reps;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (seed == 4'd0) begin
            chk("err_pulse", {29'd0, err_seed, busy, dout_valid}, 32'b100);
            tick();
            chk("err_clear", {29'd0, err_seed, busy, dout_valid}, 32'b000);
            return;
        end
        if (len == 8'd0 || reps == 8'd0) begin
            chk("empty_done", {29'd0, done, busy, dout_valid}, 32'b110);
            tick();
            chk("empty_idle", {29'd0, done, busy, dout_valid}, 32'b000);
            return;
        end
        chk("load_cycle", {29'd0, dout_valid, busy, done}, 32'b010);
        tick();
        idx = 0; done_reps = 0; low = 0; vk = 0; in_gap = 0; fin = 0;
        for (int k = 0; k < 4000 && !fin; k++) begin
            if (done) begin
                chk("done_reps", done_reps, reps);
                chk("done_state", {30'd0, dout_valid, busy}, 32'b01);
                fin = 1;
            end else begin
                chk("busy_run", {30'd0, busy, err_seed}, 32'b10);
                if (dout_valid) begin
                    if (in_gap) begin
                        chk("gap_len", low, 32'(gap) + 32'd1);
                        in_gap = 0;
                    end
                    chk("dout", dout, ref_bits[idx]);
                    chk("last", dout_last, (idx == int'(len) - 1));
                    case (rdy_mode)
                        1:       rdy = 1'($urandom_range(0, 1));
                        2:       rdy = (vk < 9) ? rdy_pat[vk] : 1'b1;
                        default: rdy = 1'b1;
                    endcase
                    vk++;
                    if (rdy) begin
                        idx++;
                        if (idx == int'(len)) begin
                            idx = 0;
                            done_reps++;
                            if (done_reps < int'(reps)) begin
                                in_gap = 1;
                                low = 0;
                            end
                        end
                    end
                end else begin
                    chk("idle_bits", {30'd0, dout, dout_last}, 32'd0);
                    if (in_gap) low++;
                    rdy = 1'($urandom_range(0, 1));
                end
                // start and cfg must be ignored while busy
                start    = 1'($urandom_range(0, 1));
                cfg_seed = 4'($urandom);
                cfg_len  = 8'($urandom);
                cfg_gap  = 4'($urandom);
                cfg_reps = 8'($urandom);
                tick();
            end
        end
        start = 1'b0;
        rdy   = 1'b1;
        if (!fin) begin
            chk("timeout", 32'd0, 32'd1);
        end else begin
            tick();
            chk("post_done", {29'd0, busy, done, dout_valid}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] exp15;
        logic [3:0]  s;
        logic [7:0]  l, r;
        logic [3:0]  g;

        rst = 1'b1; start = 1'b0; abort = 1'b0; rdy = 1'b1;
        cfg_seed = '0; cfg_len = '0; cfg_gap = '0; cfg_reps = '0;
        tick();
        chk_idle("reset_outputs");
        chk("reset_lfsr", dut.u_lfsr.state_o, 4'b1000);
        #2 rst = 1'b0;
        tick();
        chk_idle("post_reset_idle");

        // Full period from the default seed with exact cycle timing.
        exp15 = 15'b000100110101111;
        cfg_seed = 4'b1000; cfg_len = 8'd15; cfg_gap = 4'd0; cfg_reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_load", {30'd0, dout_valid, busy}, 32'b01);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("t1_valid", dout_valid, 1'b1);
            chk("t1_bit", dout, exp15[14-i]);
            chk("t1_last", dout_last, (i == 14));
            tick();
        end
        chk("t1_done", {29'd0, done, busy, dout_valid}, 32'b110);
        tick();
        chk_idle("t1_idle");

        // Backpressure pattern 1,0,0,1,1,0,1,1,1 (LSB first).
        rdy_mode = 2;
        rdy_pat  = 32'b1_1101_1001;
        run_cmd(4'b1000, 8'd6, 4'd0, 8'd1);
        rdy_mode = 0;

        // Two identical bursts separated by a gap.
        run_cmd(4'b1000, 8'd4, 4'd3, 8'd2);

        // Rejected and empty commands.
        run_cmd(4'b0000, 8'd5, 4'd0, 8'd1);
        chk_idle("zero_seed_idle");
        run_cmd(4'b1000, 8'd0, 4'd0, 8'd1);
        run_cmd(4'b0110, 8'd3, 4'd0, 8'd0);

        // Abort on beat 3 of a 10-bit burst.
        build_ref(4'b1000, 10);
        cfg_seed = 4'b1000; cfg_len = 8'd10; cfg_gap = 4'd0; cfg_reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ab_beat1", dout, ref_bits[0]);
        tick();
        chk("ab_beat2", dout, ref_bits[1]);
        tick();
        chk("ab_beat3", {30'd0, dout_valid, dout}, {30'd0, 1'b1, ref_bits[2]});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab_idle");
        chk("ab_lfsr", dut.u_lfsr.state_o, 4'b1000);
        tick();
        chk_idle("ab_no_done");
        run_cmd(4'b1000, 8'd10, 4'd1, 8'd2);

        // Abort in IDLE wins over start.
        cfg_seed = 4'b1000; cfg_len = 8'd3; cfg_reps = 8'd1;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle("idle_abort_1");
        tick();
        chk_idle("idle_abort_2");

        // Asynchronous reset in the middle of a burst.
        cfg_seed = 4'b0101; cfg_len = 8'd20; cfg_gap = 4'd0; cfg_reps = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_valid", dout_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_idle("async_rst_outputs");
        chk("async_rst_lfsr", dut.u_lfsr.state_o, 4'b1000);
        #2 rst = 1'b0;
        tick();
        chk_idle("async_rst_release");

        // Randomized commands with random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 25; n++) begin
            s = 4'($urandom_range(0, 15));
            l = 8'($urandom_range(0, 40));
            g = 4'($urandom_range(0, 5));
            r = 8'($urandom_range(0, 3));
            run_cmd(s, l, g, r);
            tick();
        end
        rdy_mode = 0;
        run_cmd(4'b1111, 8'd255, 4'd15, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prbs_burst_ctrl.md
Name: prbs_burst_ctrl

Overview:
Controller that sequences a 4-bit PRBS generator into configurable, repeatable bursts for link and BER test traffic. Accepts a start command with a seed, burst length, repeat count and inter-burst gap, then streams one PRBS bit per accepted beat on a valid/ready interface. Sits between the test-control register block and the serializer or checker under test. Owns the LFSR through a load/enable sub-module.

Parameters:
LEN_W, 8, width of burst length (bits per burst, 1..2^LEN_W-1)
GAP_W, 4, width of inter-burst gap count
REP_W, 8, width of repeat count
SEED_DEFAULT, 4'b1000, LFSR value held in reset and IDLE

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe, sampled in IDLE only
cfg_seed  in  4  LFSR seed, latched on accepted start
cfg_len  in  LEN_W  bits per burst, latched on start
cfg_gap  in  GAP_W  idle cycles between bursts, latched on start
cfg_reps  in  REP_W  number of bursts, latched on start
abort  in  1  terminate current run
dout  out  1  PRBS bit; 0 when dout_valid=0
dout_valid  out  1  beat valid
dout_ready  in  1  downstream accept
dout_last  out  1  high with final beat of each burst
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at normal completion
err_seed  out  1  one-cycle pulse when start rejected for zero seed

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. State IDLE, LFSR=SEED_DEFAULT, all counters 0, every output 0.
- LFSR: state s[3:0]; dout=s[0]; next={s[1]^s[0], s[3], s[2], s[1]}; period 15. From 1000 the bit sequence is 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1 and repeats.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE: start=1 with cfg_seed=0 -> err_seed pulse next cycle, stay IDLE. start=1 with cfg_len=0 or cfg_reps=0 -> DONE (no beats). Otherwise latch cfg, go to LOAD.
- LOAD (1 cycle): LFSR<=latched seed, bit counter<=len, go to RUN. The first valid beat appears 2 cycles after the start edge.
- RUN: dout_valid=1. On valid&ready: LFSR advances, bit counter decrements. dout_last=1 when counter==1. While ready=0, dout and dout_last are held stable.
- End of burst (last beat accepted): rep counter decrements. If reps remain and gap>0 -> GAP. If reps remain and gap=0 -> LOAD. If no reps remain -> DONE.
- GAP: dout_valid=0 for exactly cfg_gap cycles, then LOAD. Total valid-low cycles between bursts = gap+1.
- Each burst restarts from the latched seed, so all bursts are bit-identical.
- Bursts longer than 15 wrap through the LFSR period without reseeding.
- DONE (1 cycle): done=1, busy=1, then IDLE.
- start outside IDLE: ignored.
- abort: from LOAD/RUN/GAP/DONE -> IDLE on the next edge. No done pulse. LFSR returns to SEED_DEFAULT. A handshake in the same cycle as abort completes normally. abort in IDLE has priority over start.
- rst mid-run: immediate return to reset values; no done pulse.

Decomposition:
- Package prbs_pkg: state enum, LFSR_W=4, SEED_DEFAULT, tap positions / next-state function.
- Sub-module prbs4_lfsr: clk, rst, load, seed, en, state. load has priority over en. Same polynomial as above.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0, busy=0, LFSR=1000 immediately.
- seed=1000, len=15, reps=1, ready=1: start at cycle 0 -> beats cycles 2..16 = 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1; dout_last on the 15th beat; done at cycle 17; busy low at 18.
- Backpressure, seed=1000, len=6: ready pattern 1,0,0,1,1,0,1,1,1 -> accepted bits 0,0,0,1,0,0; dout stable across ready=0 cycles; dout_last held until accepted.
- reps=2, gap=3, len=4, seed=1000: bits 0001, then 4 cycles valid=0, then 0001 again; dout_last on beats 4 and 8; single done pulse.
- seed=0000: start -> err_seed pulse, busy stays 0, no beats. len=0 with valid seed: done pulse, no beats.
- abort on beat 3 of len=10 with ready=1 -> beat 3 transferred; valid=0 and busy=0 next cycle; no done. New start then runs correctly from seed.
